arcade_input_ctrl: RTL and testbench
====================================

# arcade_input_ctrl

Player-input conditioning stage sitting directly upstream of `bombjack_top` in the `emu` wrapper. Merges the PS/2 keyboard event stream from `hps_io` with both joystick words, applies the Vert/Horz orientation remap, and produces registered P1/P2 control levels. Generates a frame-timed coin pulse with lockout, so the game sees one clean coin per start request.

## Interface
Parameters:
- `COIN_FRAMES`, 4: number of frame ticks `p1_coin` is held high per coin.
- `LOCKOUT_FRAMES`, 8: frame ticks after a coin pulse during which new requests are ignored.

Ports:
- `clk_sys` in 1: system clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 66: hps_io key event; bit 64 toggles on each new event, [15:8]=F0 means release, E0 prefix means extended.
- `joystick_0` in 16: joystick word; bit 0 right, 1 left, 2 down, 3 up, 4 jump, 5 start.
- `joystick_1` in 16: second joystick word, same bit layout; ORed with `joystick_0`.
- `rotate` in 1: 1 = Horz orientation (status[2]); remaps directions.
- `vblank` in 1: from video; its rising edge is the frame tick.
- `p1_up`, `p1_down`, `p1_left`, `p1_right`, `p1_jump`, `p1_start` out 1 each: registered control levels.
- `p1_coin` out 1: coin pulse.
- `p2_start` out 1: registered F2 key level.

## Operation
- Reset: all outputs 0, all key latches 0, coin FSM IDLE, counters 0, `primed` flag 0.
- Key decode:
  - `pressed` = ([15:8] != F0).
  - `code` = {extended, [7:0]}, forced to 0 when [63:24] is nonzero (filters PRNSCR/PAUSE).
  - Event = registered bit 64 differs from current bit 64, and `primed`=1.
  - First cycle after reset only captures bit 64 and sets `primed`; it never generates an event.
- Key map (extended bit ignored for arrows): x75 up, x72 down, x6B left, x74 right, 029 jump, 005 F1 (p1 start), 006 F2 (p2 start). Other codes are ignored. Each mapped latch takes the value of `pressed`.
- Joystick merge: `joy` = `joystick_0` | `joystick_1`.
- Orientation, `rotate`=0: up = kup|joy[3], down = kdn|joy[2], left = klf|joy[1], right = krt|joy[0].
- Orientation, `rotate`=1: up = klf|joy[1], down = krt|joy[0], left = kdn|joy[2], right = kup|joy[3].
- `p1_jump` = kjump|joy[4]. `p1_start` = kF1|joy[5]. `p2_start` = kF2.
- Coin FSM:
  - Request `req` = `p1_start` | `p2_start`, computed pre-register.
  - IDLE: a `req` rising edge moves to ACTIVE with count cleared, and `p1_coin`<=1.
  - ACTIVE: count frame ticks; on the tick making count==COIN_FRAMES, `p1_coin`<=0, count cleared, go to LOCKOUT.
  - LOCKOUT: on the tick making count==LOCKOUT_FRAMES, go to IDLE.
  - `req` edges in ACTIVE/LOCKOUT are dropped, not queued. A level still held on return to IDLE does not retrigger; a fresh rising edge is required.
- Counter width: $clog2(max(COIN_FRAMES,LOCKOUT_FRAMES)+1). Counters saturate, never wrap.
- A press and a release of the same key never occur in one cycle (one event per toggle). The last event wins.

## Timing
- Joystick or `rotate` change -> outputs change on the next `clk_sys` edge (1-cycle latency).
- ps2 toggle change at edge N is registered by edge N+1 (event detected); the key latch updates at edge N+1 and outputs update at edge N+2.
- Frame tick: `vblank` is registered once; tick = cur & ~prev, 1 cycle wide, 1 cycle after the `vblank` rise.
- `p1_coin` rises 1 cycle after the `req` edge and stays high for exactly COIN_FRAMES ticks.
- `reset_n` asserted mid-pulse: `p1_coin` drops asynchronously; the FSM returns to IDLE.

## Structure
- `arcade_input_pkg`: key code constants, joystick bit indices, coin FSM enum {IDLE, ACTIVE, LOCKOUT}.
- Sub-module `ps2_key_decoder`: toggle detection, priming, code filter, key latches; outputs a 7-bit key level vector. Orientation, merging and the coin FSM live in the top.

## Test plan
- Reset with `ps2_key[64]`=1 and a valid up code, then release reset: `p1_up` stays 0 (no spurious event).
- Toggle bit 64 with code 0x75 and [15:8]=0x00: `p1_up`=1 two cycles later. Toggle again with [15:8]=F0: `p1_up`=0.
- `rotate`=1, `joystick_1`=0x0008 (up): `p1_right`=1 and `p1_up`=0 after 1 cycle.
- Code 0x75 with [63:24]=1: no output change (filtered).
- F1 press, defaults: `p1_coin` high for exactly 4 vblank rises. A second F1 press during lockout gives no pulse. A press after 8 further rises gives a new 4-frame pulse.
- Assert `reset_n` at frame 2 of ACTIVE: `p1_coin`=0 immediately. After release, F1 held: no coin until it is released and pressed again.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - shared constants and types for player-input conditioning
package arcade_input_pkg;

  // PS/2 prefix bytes carried in the hps_io key event word
  localparam logic [7:0] PS2_RELEASE = 8'hF0;
  localparam logic [7:0] PS2_EXTEND  = 8'hE0;

  // Arrow keys match on the low byte only; the extended bit is ignored for them
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  // Non-arrow keys match the full {extended, code} value
  localparam logic [8:0] KEY_JUMP = 9'h029;
  localparam logic [8:0] KEY_F1   = 9'h005;
  localparam logic [8:0] KEY_F2   = 9'h006;

  // Bit positions inside the decoder's key level vector
  localparam int KI_UP    = 0;
  localparam int KI_DOWN  = 1;
  localparam int KI_LEFT  = 2;
  localparam int KI_RIGHT = 3;
  localparam int KI_JUMP  = 4;
  localparam int KI_F1    = 5;
  localparam int KI_F2    = 6;
  localparam int NUM_KEYS = 7;

  // Joystick word bit layout
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_JUMP  = 4;
  localparam int JOY_START = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    LOCKOUT = 2'd2
  } coin_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 event toggle detection and per-key level latches
module ps2_key_decoder
  import arcade_input_pkg::*;
(
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [65:0]         ps2_key,
  output logic [NUM_KEYS-1:0] key_level
);

  logic       toggle_q;
  logic       primed;
  logic       pressed;
  logic       extended;
  logic [8:0] code;
  logic       key_event;

  // Bit 65 carries nothing this stage needs
  logic unused_ps2;
  assign unused_ps2 = ps2_key[65];

  // Decode the event word; long sequences (PRNSCR/PAUSE) collapse to a null code
  always_comb begin
    pressed   = (ps2_key[15:8] != PS2_RELEASE);
    extended  = (ps2_key[15:8] == PS2_EXTEND) || (ps2_key[23:16] == PS2_EXTEND);
    code      = (|ps2_key[63:24]) ? 9'd0 : {extended, ps2_key[7:0]};
    key_event = primed && (ps2_key[64] != toggle_q);
  end

  // Track the toggle bit; the first cycle after reset only primes so a stale bit is not an event
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      primed   <= 1'b0;
    end else begin
      toggle_q <= ps2_key[64];
      primed   <= 1'b1;
    end
  end

  // Each mapped key latch follows the press/release state of its latest event
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_level <= '0;
    end else if (key_event) begin
      if (code[7:0] == KEY_UP && code != 9'd0) begin
        key_level[KI_UP] <= pressed;
      end else if (code[7:0] == KEY_DOWN) begin
        key_level[KI_DOWN] <= pressed;
      end else if (code[7:0] == KEY_LEFT) begin
        key_level[KI_LEFT] <= pressed;
      end else if (code[7:0] == KEY_RIGHT) begin
        key_level[KI_RIGHT] <= pressed;
      end else if (code == KEY_JUMP) begin
        key_level[KI_JUMP] <= pressed;
      end else if (code == KEY_F1) begin
        key_level[KI_F1] <= pressed;
      end else if (code == KEY_F2) begin
        key_level[KI_F2] <= pressed;
      end
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// rtl/arcade_input_ctrl.sv - keyboard/joystick merge, orientation remap and coin pulse generator
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_FRAMES    = 4,
  parameter int LOCKOUT_FRAMES = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [65:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        vblank,
  output logic        p1_up,
  output logic        p1_down,
  output logic        p1_left,
  output logic        p1_right,
  output logic        p1_jump,
  output logic        p1_start,
  output logic        p1_coin,
  output logic        p2_start
);

  localparam int CNT_LIMIT = max_int(COIN_FRAMES, LOCKOUT_FRAMES);
  localparam int CNT_W     = $clog2(CNT_LIMIT + 1);

  logic [NUM_KEYS-1:0] keys;
  logic [15:0]         joy;
  logic                log_up, log_down, log_left, log_right;
  logic                up_n, down_n, left_n, right_n, jump_n, start_n, f2_n;
  logic                req, req_q, req_rise;
  logic                vblank_q, frame_tick;
  coin_state_e         coin_state;
  logic [CNT_W-1:0]    frame_cnt;
  logic [CNT_W-1:0]    cnt_inc;

  // Upper joystick bits are buttons this game does not use
  logic unused_joy;
  assign unused_joy = ^joy[15:6];

  ps2_key_decoder u_decoder (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .key_level (keys)
  );

  // Merge sources, then rotate the direction set for Horz cabinets
  always_comb begin
    joy       = joystick_0 | joystick_1;
    log_up    = keys[KI_UP]    | joy[JOY_UP];
    log_down  = keys[KI_DOWN]  | joy[JOY_DOWN];
    log_left  = keys[KI_LEFT]  | joy[JOY_LEFT];
    log_right = keys[KI_RIGHT] | joy[JOY_RIGHT];
    if (rotate) begin
      up_n    = log_left;
      down_n  = log_right;
      left_n  = log_down;
      right_n = log_up;
    end else begin
      up_n    = log_up;
      down_n  = log_down;
      left_n  = log_left;
      right_n = log_right;
    end
    jump_n     = keys[KI_JUMP] | joy[JOY_JUMP];
    start_n    = keys[KI_F1]   | joy[JOY_START];
    f2_n       = keys[KI_F2];
    req        = start_n | f2_n;
    req_rise   = req & ~req_q;
    frame_tick = vblank & ~vblank_q;
    cnt_inc    = (frame_cnt == {CNT_W{1'b1}}) ? frame_cnt : frame_cnt + 1'b1;
  end

  // Register control levels plus the request and vblank history used for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1_up    <= 1'b0;
      p1_down  <= 1'b0;
      p1_left  <= 1'b0;
      p1_right <= 1'b0;
      p1_jump  <= 1'b0;
      p1_start <= 1'b0;
      p2_start <= 1'b0;
      req_q    <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      p1_up    <= up_n;
      p1_down  <= down_n;
      p1_left  <= left_n;
      p1_right <= right_n;
      p1_jump  <= jump_n;
      p1_start <= start_n;
      p2_start <= f2_n;
      req_q    <= req;
      vblank_q <= vblank;
    end
  end

  // Coin FSM: one frame-timed pulse per request edge, then a lockout that drops further edges
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_state <= IDLE;
      frame_cnt  <= '0;
      p1_coin    <= 1'b0;
    end else begin
      case (coin_state)
        IDLE: begin
          if (req_rise) begin
            coin_state <= ACTIVE;
            frame_cnt  <= '0;
            p1_coin    <= 1'b1;
          end
        end
        ACTIVE: begin
          if (frame_tick) begin
            if (cnt_inc == CNT_W'(COIN_FRAMES)) begin
              coin_state <= LOCKOUT;
              frame_cnt  <= '0;
              p1_coin    <= 1'b0;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
        end
        LOCKOUT: begin
          if (frame_tick) begin
            if (cnt_inc == CNT_W'(LOCKOUT_FRAMES)) begin
              coin_state <= IDLE;
              frame_cnt  <= '0;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
        end
        default: begin
          coin_state <= IDLE;
          frame_cnt  <= '0;
          p1_coin    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb/tb_arcade_input_ctrl.sv - self-checking bench for arcade_input_ctrl
module tb_arcade_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [65:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        rotate, vblank;
  logic        p1_up, p1_down, p1_left, p1_right, p1_jump, p1_start, p1_coin, p2_start;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic tgl;
  bit held [7];

  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl #(.COIN_FRAMES(4), .LOCKOUT_FRAMES(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate), .vblank(vblank),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
    .p1_jump(p1_jump), .p1_start(p1_start), .p1_coin(p1_coin), .p2_start(p2_start)
  );

  typedef struct {
    logic [15:0] j0;
    logic [15:0] j1;
    bit          rot;
    logic [5:0]  exp; // {start, jump, right, left, down, up}
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic frame();
    vblank = 1'b1;
    step(2);
    vblank = 1'b0;
    step(2);
  endtask

  task automatic send_key(input logic [7:0] code, input bit ext, input bit rel, input bit filt);
    logic [65:0] k;
    k = '0;
    k[7:0] = code;
    if (rel) begin
      k[15:8] = 8'hF0;
      if (ext) k[23:16] = 8'hE0;
    end else if (ext) begin
      k[15:8] = 8'hE0;
    end
    if (filt) k[24] = 1'b1;
    tgl = ~tgl;
    k[64] = tgl;
    ps2_key = k;
  endtask

  function automatic logic [6:0] dut_outs();
    return {p2_start, p1_start, p1_jump, p1_right, p1_left, p1_down, p1_up};
  endfunction

  // Reference: what the player holds, seen through a cabinet rotated 90 degrees when rot=1
  function automatic logic [6:0] model(input logic [15:0] j, input bit rot);
    logic u, d, l, r;
    logic su, sd, sl, sr;
    u = held[0] | j[3];
    d = held[1] | j[2];
    l = held[2] | j[1];
    r = held[3] | j[0];
    if (rot) begin su = l; sd = r; sl = d; sr = u; end
    else     begin su = u; sd = d; sl = l; sr = r; end
    return {held[6], held[5] | j[5], held[4] | j[4], sr, sl, sd, su};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) held[i] = 1'b0;
    step(3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] arrows [4];
    int n;
    bit seen;
    arrows[0] = 8'h75; arrows[1] = 8'h72; arrows[2] = 8'h6B; arrows[3] = 8'h74;

    vecs[0] = '{16'h0001, 16'h0000, 1'b0, 6'b001000};
    vecs[1] = '{16'h0008, 16'h0000, 1'b0, 6'b000001};
    vecs[2] = '{16'h0000, 16'h0008, 1'b1, 6'b001000};
    vecs[3] = '{16'h0002, 16'h0000, 1'b1, 6'b000001};
    vecs[4] = '{16'h0004, 16'h0000, 1'b1, 6'b000100};
    vecs[5] = '{16'h0000, 16'h0001, 1'b1, 6'b000010};
    vecs[6] = '{16'h0010, 16'h0020, 1'b0, 6'b110000};
    vecs[7] = '{16'h0005, 16'h0002, 1'b0, 6'b001110};
    vecs[8] = '{16'h0005, 16'h0002, 1'b1, 6'b000111};
    vecs[9] = '{16'hFFC0, 16'h0000, 1'b0, 6'b000000};

    // Reset with a stale toggle and a valid up code on the bus
    joystick_0 = '0; joystick_1 = '0; rotate = 1'b0; vblank = 1'b0;
    tgl = 1'b0;
    reset_n = 1'b0;
    send_key(8'h75, 1'b0, 1'b0, 1'b0);
    step(3);
    check("reset_outs", {8'd0, p1_coin, dut_outs()}, 16'h0);
    reset_n = 1'b1;
    step(5);
    check("no_spurious_up", p1_up, 1'b0);

    // Key press / release latency
    send_key(8'h75, 1'b0, 1'b0, 1'b0);
    step(1);
    check("up_latency_1", p1_up, 1'b0);
    step(1);
    check("up_press", p1_up, 1'b1);
    send_key(8'h75, 1'b0, 1'b1, 1'b0);
    step(2);
    check("up_release", p1_up, 1'b0);
    send_key(8'h75, 1'b0, 1'b0, 1'b1);
    step(3);
    check("filtered_code", p1_up, 1'b0);
    send_key(8'h6B, 1'b1, 1'b0, 1'b0);
    step(2);
    check("ext_left_press", p1_left, 1'b1);
    send_key(8'h6B, 1'b1, 1'b1, 1'b0);
    step(2);
    check("ext_left_release", p1_left, 1'b0);

    // Table: joystick merge and orientation
    for (int i = 0; i < 10; i++) begin
      joystick_0 = vecs[i].j0;
      joystick_1 = vecs[i].j1;
      rotate     = vecs[i].rot;
      step(1);
      check($sformatf("vec%0d", i), {p1_start, p1_jump, p1_right, p1_left, p1_down, p1_up}, vecs[i].exp);
    end
    joystick_0 = '0; joystick_1 = '0; rotate = 1'b0;

    // Randomized keys and joysticks against the reference model
    do_reset();
    for (int it = 0; it < 150; it++) begin
      int sel;
      bit rel;
      joystick_0 = 16'($urandom_range(0, 63) & $urandom_range(0, 63));
      joystick_1 = 16'($urandom_range(0, 63) & $urandom_range(0, 63));
      rotate = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        sel = $urandom_range(0, 9);
        rel = 1'($urandom_range(0, 1));
        case (sel)
          0, 1, 2, 3: send_key(arrows[sel], 1'($urandom_range(0, 1)), rel, 1'b0);
          4: send_key(8'h29, 1'b0, rel, 1'b0);
          5: send_key(8'h05, 1'b0, rel, 1'b0);
          6: send_key(8'h06, 1'b0, rel, 1'b0);
          7: send_key(8'h1C, 1'b0, rel, 1'b0);
          8: send_key(arrows[$urandom_range(0, 3)], 1'b0, rel, 1'b1);
          default: send_key(8'h05, 1'b1, rel, 1'b0);
        endcase
        if (sel < 7) held[sel] = !rel;
      end
      step(2);
      check($sformatf("rand%0d", it), dut_outs(), model(joystick_0 | joystick_1, rotate));
    end
    joystick_0 = '0; joystick_1 = '0; rotate = 1'b0;

    // Coin pulse: latency and width
    do_reset();
    send_key(8'h05, 1'b0, 1'b0, 1'b0);
    step(1);
    check("coin_latency", p1_coin, 1'b0);
    step(1);
    check("coin_rise", p1_coin, 1'b1);
    n = 0;
    while (p1_coin && n < 20) begin frame(); n++; end
    check("coin_width", n, 4);

    // Lockout drops a new press
    send_key(8'h05, 1'b0, 1'b1, 1'b0);
    step(2);
    frame(); frame();
    send_key(8'h05, 1'b0, 1'b0, 1'b0);
    step(2);
    seen = p1_coin;
    for (int f = 0; f < 6; f++) begin frame(); seen |= p1_coin; end
    check("lockout_drop", seen, 1'b0);
    step(4);
    check("held_no_retrigger", p1_coin, 1'b0);

    // Fresh edge after lockout gives a new full pulse
    send_key(8'h05, 1'b0, 1'b1, 1'b0);
    step(2);
    send_key(8'h05, 1'b0, 1'b0, 1'b0);
    step(2);
    check("coin_retrigger", p1_coin, 1'b1);
    n = 0;
    while (p1_coin && n < 20) begin frame(); n++; end
    check("coin_width_2", n, 4);
    for (int f = 0; f < 8; f++) frame();

    // Reset mid-pulse drops coin immediately; held F1 does not retrigger
    send_key(8'h05, 1'b0, 1'b1, 1'b0);
    step(2);
    send_key(8'h05, 1'b0, 1'b0, 1'b0);
    step(2);
    check("coin_before_reset", p1_coin, 1'b1);
    frame(); frame();
    #2;
    reset_n = 1'b0;
    #1;
    check("coin_async_reset", p1_coin, 1'b0);
    step(2);
    reset_n = 1'b1;
    step(10);
    check("coin_after_reset_held", {p1_start, p1_coin}, 2'b00);
    send_key(8'h05, 1'b0, 1'b1, 1'b0);
    step(2);
    send_key(8'h05, 1'b0, 1'b0, 1'b0);
    step(2);
    check("coin_after_repress", p1_coin, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
